// File: rtl/multicycle_control.sv
// multicycle_control
// ------------------
// Multi-cycle control unit for an RV32I core. Every instruction is walked
// through FETCH / DECODE / EXECUTE / (MEM) / (WB). The unit drives the
// datapath enables and a req/ready memory handshake. It also traps on an
// illegal opcode or on a memory request that waits too long.
//
// Parameters
//   MEM_TIMEOUT   : maximum cycles mem_req may wait for mem_ready before a
//                   bus-timeout trap is taken; 0 disables the timeout
//   SUPPORT_JUMPS : 1 = JAL/JALR/LUI/AUIPC legal, 0 = they trap as illegal
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   run           : leave IDLE and start fetching (sampled in IDLE only)
//   instr         : fetched instruction, valid while mem_ready=1 in FETCH
//   mem_ready     : memory completes the current request
//   branch_taken  : ALU compare result, sampled in EXECUTE
//   trap_ack      : trap handler acknowledge
//   mem_req/iord/mem_write/mem_read : memory request and qualifiers
//   ir_write/pc_write/pc_src        : instruction register and PC control
//   alu_src/reg_write/mem_to_reg    : datapath and register file control
//   trap/trap_cause                 : trap pending and cause (1 illegal, 2 timeout)
//   state_o                         : current state, for debug
//
// Memory handshake: mem_req rises when the unit enters FETCH or MEM. It stays
// high, with iord/mem_read/mem_write stable, until the memory answers with
// mem_ready=1. The request completes in the cycle where mem_req and mem_ready
// are both high. mem_req drops only on that completion, on a timeout trap, or
// on reset.

module multicycle_control #(
    parameter int MEM_TIMEOUT   = 16,
    parameter bit SUPPORT_JUMPS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    input  logic        trap_ack,
    output logic        mem_req,
    output logic        iord,
    output logic        mem_write,
    output logic        mem_read,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // The trap fires on the wait cycle that would bring the count up to
    // MEM_TIMEOUT. The compare is against MEM_TIMEOUT-1 on the old count.
    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [15:0] wait_cnt;
    logic [1:0]  cause_q;

    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_jump_class;
    logic        legal;
    logic        timeout_hit;
    logic [15:0] wait_inc;

    // funct3 is latched for the datapath's benefit. The remaining
    // instruction fields belong to the datapath, not the sequencer.
    logic unused_bits;
    assign unused_bits = ^{instr[31:15], instr[11:7], funct3_q};

    assign is_load       = (opcode_q == OP_LOAD);
    assign is_store      = (opcode_q == OP_STORE);
    assign is_branch     = (opcode_q == OP_BRANCH);
    assign is_jal        = (opcode_q == OP_JAL);
    assign is_jalr       = (opcode_q == OP_JALR);
    assign is_jump_class = is_jal || is_jalr ||
                           (opcode_q == OP_LUI) || (opcode_q == OP_AUIPC);
    assign legal         = (opcode_q == OP_R) || (opcode_q == OP_IMM) ||
                           is_load || is_store || is_branch ||
                           (SUPPORT_JUMPS && is_jump_class);

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);
    assign wait_inc    = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    // Sequencer. The wait counter defaults to zero every cycle, so it clears
    // on every state change. It only counts while a request stays unanswered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            opcode_q <= 7'd0;
            funct3_q <= 3'd0;
            wait_cnt <= 16'd0;
            cause_q  <= 2'd0;
        end else begin
            wait_cnt <= 16'd0;
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        opcode_q <= instr[6:0];
                        funct3_q <= instr[14:12];
                        state    <= S_DECODE;
                    end else if (timeout_hit) begin
                        cause_q <= 2'd2;
                        state   <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        cause_q <= 2'd1;
                        state   <= S_TRAP;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_load || is_store)
                        state <= S_MEM;
                    else if (is_branch || is_jal || is_jalr)
                        state <= S_FETCH;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= is_load ? S_WB : S_FETCH;
                    end else if (timeout_hit) begin
                        cause_q <= 2'd2;
                        state   <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_TRAP: begin
                    if (trap_ack) begin
                        cause_q <= 2'd0;
                        state   <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode. Everything comes from registered state, so reset forces
    // all outputs low at once. ir_write/pc_write must follow mem_ready and
    // branch_taken within the same cycle, so they are gated here rather than
    // registered.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXECUTE: begin
                alu_src = (opcode_q != OP_R);
                if (is_branch && branch_taken) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd1;
                end
                if (is_jal || is_jalr) begin
                    pc_write  = 1'b1;
                    pc_src    = is_jalr ? 2'd2 : 2'd1;
                    reg_write = 1'b1;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed scoreboard bench. Unit "a" has MEM_TIMEOUT=4 and SUPPORT_JUMPS=1.
// Unit "b" has MEM_TIMEOUT=0 and SUPPORT_JUMPS=0. Each driven cycle pushes the
// hand-computed output vector onto that unit's queue. A monitor on the falling
// edge pops each vector and compares it against the live outputs.

module tb_multicycle_control;

    localparam int W = 17;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_JALR = 32'h00008067;
    localparam logic [31:0] I_ILL  = 32'h0000007F;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LUI  = 32'h000010B7;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // unit a signals
    logic        run_a = 0, rdy_a = 0, bt_a = 0, ack_a = 0;
    logic [31:0] ins_a = '0;
    logic        req_a, iord_a, mw_a, mr_a, irw_a, pcw_a, als_a, rw_a, m2r_a, trap_a;
    logic [1:0]  pcs_a, cause_a;
    logic [2:0]  st_a;
    // unit b signals
    logic        run_b = 0, rdy_b = 0, bt_b = 0, ack_b = 0;
    logic [31:0] ins_b = '0;
    logic        req_b, iord_b, mw_b, mr_b, irw_b, pcw_b, als_b, rw_b, m2r_b, trap_b;
    logic [1:0]  pcs_b, cause_b;
    logic [2:0]  st_b;

    multicycle_control #(.MEM_TIMEOUT(4), .SUPPORT_JUMPS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .run(run_a), .instr(ins_a), .mem_ready(rdy_a),
        .branch_taken(bt_a), .trap_ack(ack_a), .mem_req(req_a), .iord(iord_a),
        .mem_write(mw_a), .mem_read(mr_a), .ir_write(irw_a), .pc_write(pcw_a),
        .pc_src(pcs_a), .alu_src(als_a), .reg_write(rw_a), .mem_to_reg(m2r_a),
        .trap(trap_a), .trap_cause(cause_a), .state_o(st_a)
    );

    multicycle_control #(.MEM_TIMEOUT(0), .SUPPORT_JUMPS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .instr(ins_b), .mem_ready(rdy_b),
        .branch_taken(bt_b), .trap_ack(ack_b), .mem_req(req_b), .iord(iord_b),
        .mem_write(mw_b), .mem_read(mr_b), .ir_write(irw_b), .pc_write(pcw_b),
        .pc_src(pcs_b), .alu_src(als_b), .reg_write(rw_b), .mem_to_reg(m2r_b),
        .trap(trap_b), .trap_cause(cause_b), .state_o(st_b)
    );

    logic [W-1:0] got_a, got_b;
    assign got_a = {st_a, req_a, iord_a, mw_a, mr_a, irw_a, pcw_a, pcs_a,
                    als_a, rw_a, m2r_a, trap_a, cause_a};
    assign got_b = {st_b, req_b, iord_b, mw_b, mr_b, irw_b, pcw_b, pcs_b,
                    als_b, rw_b, m2r_b, trap_b, cause_b};

    // scoreboard
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    string        nm_a_q[$];
    string        nm_b_q[$];
    int           errors = 0;
    int           checks = 0;

    // Field order: state, mem_req, iord, mem_write, mem_read, ir_write,
    // pc_write, pc_src, alu_src, reg_write, mem_to_reg, trap, trap_cause.
    function automatic logic [W-1:0] ev(input logic [2:0] st, input logic req,
                                        input logic io, input logic mw, input logic mr,
                                        input logic irw, input logic pcw,
                                        input logic [1:0] pcs, input logic als,
                                        input logic rw, input logic m2r,
                                        input logic tr, input logic [1:0] cause);
        return {st, req, io, mw, mr, irw, pcw, pcs, als, rw, m2r, tr, cause};
    endfunction

    function automatic logic [W-1:0] v_idle();
        return ev(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0);
    endfunction
    function automatic logic [W-1:0] v_fetch_done();
        return ev(3'd1, 1, 0, 0, 1, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0);
    endfunction
    function automatic logic [W-1:0] v_fetch_wait();
        return ev(3'd1, 1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0);
    endfunction
    function automatic logic [W-1:0] v_decode();
        return ev(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0);
    endfunction
    function automatic logic [W-1:0] v_exec(input logic als, input logic pcw,
                                            input logic [1:0] pcs, input logic rw);
        return ev(3'd3, 0, 0, 0, 0, 0, pcw, pcs, als, rw, 0, 0, 2'd0);
    endfunction
    function automatic logic [W-1:0] v_mem(input logic mw, input logic mr);
        return ev(3'd4, 1, 1, mw, mr, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0);
    endfunction
    function automatic logic [W-1:0] v_wb(input logic m2r);
        return ev(3'd5, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, m2r, 0, 2'd0);
    endfunction
    function automatic logic [W-1:0] v_trap(input logic [1:0] cause);
        return ev(3'd6, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, cause);
    endfunction

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, e, $time);
        end
    endtask

    // driver: apply one cycle of inputs to a unit, queue its expected outputs
    task automatic cyc(input int sel, input logic r, input logic rdy, input logic bt,
                       input logic ack, input logic [31:0] ins,
                       input logic [W-1:0] e, input string nm);
        if (sel == 0) begin
            run_a = r; rdy_a = rdy; bt_a = bt; ack_a = ack; ins_a = ins;
            exp_a_q.push_back(e); nm_a_q.push_back(nm);
        end else begin
            run_b = r; rdy_b = rdy; bt_b = bt; ack_b = ack; ins_b = ins;
            exp_b_q.push_back(e); nm_b_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input int sel, input logic [31:0] ins, input string nm);
        cyc(sel, 0, 1, 0, 0, ins, v_fetch_done(), {nm, "_fetch"});
        cyc(sel, 0, 0, 0, 0, '0, v_decode(), {nm, "_decode"});
    endtask

    // monitor
    always @(negedge clk) begin
        if (exp_a_q.size() > 0) check(nm_a_q.pop_front(), got_a, exp_a_q.pop_front());
        if (exp_b_q.size() > 0) check(nm_b_q.pop_front(), got_b, exp_b_q.pop_front());
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        #2;
        check("reset_a", got_a, v_idle());
        check("reset_b", got_b, v_idle());
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // unit b: timeout disabled, jumps unsupported
        cyc(1, 1, 0, 0, 0, '0, v_idle(), "b_idle_run");
        for (int i = 0; i < 20; i++)
            cyc(1, 0, 0, 0, 0, '0, v_fetch_wait(), "b_fetch_no_timeout");
        fetch_decode(1, I_JAL, "b_jal");
        cyc(1, 0, 0, 0, 1, '0, v_trap(2'd1), "b_jal_illegal_trap");
        cyc(1, 0, 0, 0, 0, '0, v_fetch_wait(), "b_after_trap");

        // unit a: ADD, 4 cycles
        cyc(0, 1, 0, 0, 0, '0, v_idle(), "a_idle_run");
        fetch_decode(0, I_ADD, "add");
        cyc(0, 0, 0, 0, 0, '0, v_exec(0, 0, 2'd0, 0), "add_exec");
        cyc(0, 0, 0, 0, 0, '0, v_wb(0), "add_wb");
        // LW, 3 wait cycles, ready on the 4th (limit cycle, ready wins)
        fetch_decode(0, I_LW, "lw");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 0, 2'd0, 0), "lw_exec");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, '0, v_mem(0, 1), "lw_mem_wait");
        cyc(0, 0, 1, 0, 0, '0, v_mem(0, 1), "lw_mem_done");
        cyc(0, 0, 0, 0, 0, '0, v_wb(1), "lw_wb");
        // SW
        fetch_decode(0, I_SW, "sw");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 0, 2'd0, 0), "sw_exec");
        cyc(0, 0, 1, 0, 0, '0, v_mem(1, 0), "sw_mem");
        // BEQ taken / not taken
        fetch_decode(0, I_BEQ, "beq_t");
        cyc(0, 0, 0, 1, 0, '0, v_exec(1, 1, 2'd1, 0), "beq_taken_exec");
        fetch_decode(0, I_BEQ, "beq_nt");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 0, 2'd0, 0), "beq_not_taken_exec");
        // JAL / JALR
        fetch_decode(0, I_JAL, "jal");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 1, 2'd1, 1), "jal_exec");
        fetch_decode(0, I_JALR, "jalr");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 1, 2'd2, 1), "jalr_exec");
        // illegal opcode, ack after 5 cycles
        fetch_decode(0, I_ILL, "ill");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 0, 0, '0, v_trap(2'd1), "ill_trap_hold");
        cyc(0, 0, 0, 0, 1, '0, v_trap(2'd1), "ill_trap_ack");
        // fetch timeout: 4 wait cycles then TRAP cause 2
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 0, '0, v_fetch_wait(), "to_fetch_wait");
        cyc(0, 0, 0, 0, 0, '0, v_trap(2'd2), "to_trap");
        cyc(0, 0, 0, 0, 1, '0, v_trap(2'd2), "to_trap_ack");
        // ready on the 4th wait cycle: no trap
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, '0, v_fetch_wait(), "edge_fetch_wait");
        fetch_decode(0, I_ADDI, "addi_edge");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 0, 2'd0, 0), "addi_exec");
        cyc(0, 0, 0, 0, 0, '0, v_wb(0), "addi_wb");
        // async reset mid-MEM
        fetch_decode(0, I_LW, "lw2");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 0, 2'd0, 0), "lw2_exec");
        cyc(0, 0, 0, 0, 0, '0, v_mem(0, 1), "lw2_mem_wait");
        rst = 1'b1;
        #1;
        check("async_reset_mid_mem", got_a, v_idle());
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, '0, v_idle(), "post_reset_idle");
        cyc(0, 1, 0, 0, 0, '0, v_idle(), "post_reset_run");
        fetch_decode(0, I_LUI, "lui");
        cyc(0, 0, 0, 0, 0, '0, v_exec(1, 0, 2'd0, 0), "lui_exec");
        cyc(0, 0, 0, 0, 0, '0, v_wb(0), "lui_wb");

        // drain
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d/%0d pending expected=0/0",
                     exp_a_q.size(), exp_b_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control unit for the RV32I core; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives datapath enables and a req/ready memory handshake with a timeout.
- Latches opcode/funct3 and flags illegal opcodes and bus timeouts through a trap state.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus-error trap; 0 disables timeout.
- SUPPORT_JUMPS, 1, 1 = JAL/JALR/LUI/AUIPC legal; 0 = those opcodes trap as illegal.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  leave IDLE and start fetching
- instr  in  32  fetched instruction, valid in the cycle mem_ready=1 during FETCH
- mem_ready  in  1  memory completes current request
- branch_taken  in  1  ALU compare result, sampled in EXECUTE
- trap_ack  in  1  trap handler acknowledge
- mem_req  out  1  memory request, held until mem_ready
- iord  out  1  0 = instruction address, 1 = data address
- mem_write  out  1  store request qualifier
- mem_read  out  1  load/fetch qualifier
- ir_write  out  1  latch instr
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch/JAL target, 2 = JALR target
- alu_src  out  1  0 = rs2, 1 = immediate
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback selects load data
- trap  out  1  trap pending
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = bus timeout
- state_o  out  3  current state, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=6.
- Reset (async): state IDLE, latched opcode 0, funct3 0, timeout counter 0, trap_cause 0. All outputs 0.
- IDLE: all outputs 0. run=1 -> FETCH next cycle.
- FETCH:
  - mem_req=1, mem_read=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, opcode/funct3 latched from instr -> DECODE.
- DECODE: one cycle, no enables. Transition depends on opcode.
  - Illegal opcode -> TRAP, cause 1. Legal = 0110011, 0010011, 0000011, 0100011, 1100011, plus 1101111, 1100111, 0110111, 0010111 when SUPPORT_JUMPS.
  - Otherwise -> EXECUTE.
- EXECUTE:
  - alu_src=0 only for 0110011, else 1.
  - Branch (1100011): if branch_taken then pc_write=1, pc_src=1; -> FETCH.
  - Load/store -> MEM.
  - JAL: pc_write=1, pc_src=1, reg_write=1 (link) -> FETCH.
  - JALR: same as JAL with pc_src=2.
  - Others -> WB.
- MEM:
  - mem_req=1, iord=1, mem_read=1 for load, mem_write=1 for store. Held until mem_ready.
  - Store completes -> FETCH. Load completes -> WB.
- WB: reg_write=1; mem_to_reg=1 iff load. -> FETCH.
- Timeout:
  - Counter increments each cycle mem_req=1 && mem_ready=0, clears on any state change.
  - When MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP, cause 2. mem_req drops in TRAP.
  - mem_ready in the same cycle the count hits the limit wins: normal transition, no trap.
- TRAP: trap=1, trap_cause held, all other enables 0. trap_ack=1 -> FETCH, cause cleared to 0.
- run only sampled in IDLE; dropping run mid-instruction has no effect.
- Exactly one of mem_read/mem_write is high whenever mem_req=1.
- reg_write never asserted for store/branch.
- Reset mid-operation: immediate return to IDLE, all outputs 0 in the same cycle.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready same cycle -> states 1,2,3,5,1; alu_src=0 in EXECUTE; reg_write=1 only in WB; 4 cycles per instruction.
- LW (0x0000A183), mem_ready delayed 3 cycles in MEM -> mem_req/iord/mem_read held 4 cycles; WB has mem_to_reg=1, reg_write=1.
- SW (0x0020A023) -> MEM with mem_write=1, mem_read=0; returns to FETCH with reg_write never asserted.
- BEQ: branch_taken=1 -> pc_write=1, pc_src=1 in EXECUTE; branch_taken=0 -> pc_write=0; both 3 cycles.
- Illegal opcode 0x0000007F -> TRAP, trap_cause=1; trap_ack after 5 cycles -> FETCH, trap=0. With SUPPORT_JUMPS=0, JAL (0x0000006F) also traps with cause 1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP with cause 2 after 4 wait cycles; repeat with mem_ready on the 4th cycle -> no trap. Assert rst mid-MEM -> IDLE, all outputs 0 asynchronously.
